// File: rtl/alu_system_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the ALU datapath system.
// Only the state register is clocked; every control output decodes state and IROut.
module alu_system_control_unit #(
    parameter logic [4:0] ADD_FUNSEL       = 5'b10100,
    parameter bit         INC_DEC_ON_FLAGS = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  FlagsOut,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic [1:0]  DR_FunSel,
    output logic        DR_E,
    output logic        Halted,
    output logic        IllegalOp
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH0 = 3'd1;
    localparam logic [2:0] S_FETCH1 = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_EXEC2  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] RF_DEC  = 3'b000;
    localparam logic [2:0] RF_INC  = 3'b001;
    localparam logic [2:0] RF_LOAD = 3'b010;

    logic [2:0] state;
    logic [2:0] next_state;

    logic [5:0] opcode;
    logic [1:0] rs;
    logic [3:0] rs_onehot;
    logic       flag_z;

    assign opcode    = IROut[15:10];
    assign rs        = IROut[9:8];
    assign rs_onehot = 4'b1000 >> rs;
    assign flag_z    = FlagsOut[3];

    // The immediate feeds the datapath directly; C/N/O are not consumed by this subset.
    logic unused_bits;
    assign unused_bits = ^{FlagsOut[2:0], IROut[7:0]};

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_INIT;
        else       state <= next_state;
    end

    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 2'b00;
        MuxDSel     = 1'b0;
        DR_FunSel   = 2'b00;
        DR_E        = 1'b0;
        Halted      = 1'b0;
        IllegalOp   = 1'b0;
        next_state  = state;

        if (!Reset) begin
            case (state)
                S_INIT: begin
                    ARF_RegSel = 3'b100;
                    ARF_FunSel = 2'b11;
                    next_state = S_FETCH0;
                end
                S_FETCH0, S_FETCH1: begin
                    Mem_CS      = 1'b0;
                    ARF_OutDSel = 2'b00;
                    IR_Write    = 1'b1;
                    IR_LH       = (state == S_FETCH1);
                    ARF_RegSel  = 3'b100;
                    ARF_FunSel  = 2'b01;
                    next_state  = (state == S_FETCH1) ? S_EXEC : S_FETCH1;
                end
                S_EXEC: begin
                    next_state = S_FETCH0;
                    case (opcode)
                        6'h00, 6'h01, 6'h02: begin
                            // BRA always, BNE on Z=0, BEQ on Z=1; a failed test is a no-op
                            if (opcode == 6'h00 || (opcode == 6'h01 && !flag_z) ||
                                (opcode == 6'h02 && flag_z)) begin
                                MuxBSel    = 2'b11;
                                ARF_RegSel = 3'b100;
                                ARF_FunSel = 2'b10;
                            end
                        end
                        6'h03, 6'h04: begin
                            RF_RegSel = rs_onehot;
                            RF_FunSel = (opcode == 6'h03) ? RF_INC : RF_DEC;
                            ALU_WF    = INC_DEC_ON_FLAGS;
                        end
                        6'h05: begin
                            MuxASel   = 2'b11;
                            RF_RegSel = rs_onehot;
                            RF_FunSel = RF_LOAD;
                        end
                        6'h06: begin
                            RF_OutASel = 3'b000;
                            RF_OutBSel = {1'b0, rs};
                            MuxDSel    = 1'b0;
                            ALU_FunSel = ADD_FUNSEL;
                            ALU_WF     = 1'b1;
                            MuxASel    = 2'b00;
                            RF_RegSel  = 4'b1000;
                            RF_FunSel  = RF_LOAD;
                        end
                        6'h07: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            DR_E        = 1'b1;
                            DR_FunSel   = 2'b01;
                            next_state  = S_EXEC2;
                        end
                        6'h08: next_state = S_HALT;
                        default: IllegalOp = 1'b1;
                    endcase
                end
                S_EXEC2: begin
                    MuxASel    = 2'b10;
                    RF_RegSel  = rs_onehot;
                    RF_FunSel  = RF_LOAD;
                    next_state = S_FETCH0;
                end
                S_HALT: Halted = 1'b1;
                default: next_state = S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Directed bench: stimulus pushes the hand-computed control word for each cycle,
// a monitor pops it and compares at the falling edge.
module tb_alu_system_control_unit;

    typedef struct packed {
        logic [2:0] a_sel, b_sel, rf_fun;
        logic [3:0] rf_reg, rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] c_sel, d_sel, arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh, ir_wr, mem_wr, mem_cs;
        logic [1:0] mux_a, mux_b, mux_c;
        logic       mux_d;
        logic [1:0] dr_fun;
        logic       dr_e, halted, illegal;
    } ctl_t;

    typedef struct {
        string nm;
        ctl_t  exp;
    } ent_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IROut = 16'h0000;
    logic [3:0]  FlagsOut = 4'h0;

    logic [2:0] RF_OutASel, RF_OutBSel, RF_FunSel, ARF_RegSel;
    logic [3:0] RF_RegSel, RF_ScrSel;
    logic [4:0] ALU_FunSel;
    logic       ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxDSel, DR_E, Halted, IllegalOp;
    logic [1:0] ARF_OutCSel, ARF_OutDSel, ARF_FunSel, MuxASel, MuxBSel, MuxCSel, DR_FunSel;

    alu_system_control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
        .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
        .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel), .DR_FunSel(DR_FunSel),
        .DR_E(DR_E), .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 Clock = ~Clock;

    ctl_t got;
    assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                  ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH,
                  IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, MuxDSel,
                  DR_FunSel, DR_E, Halted, IllegalOp};

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            ent_t e;
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.nm, got, e.exp);
            end
        end
    end

    function automatic ctl_t idle_v();
        ctl_t c;
        c = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch_v(input logic lh);
        ctl_t c;
        c = idle_v();
        c.mem_cs  = 1'b0;
        c.ir_wr   = 1'b1;
        c.ir_lh   = lh;
        c.arf_reg = 3'b100;
        c.arf_fun = 2'b01;
        return c;
    endfunction

    task automatic cyc(input logic r, input logic [15:0] ir, input logic [3:0] fl,
                       input ctl_t e, input string nm);
        @(posedge Clock);
        #1;
        Reset    = r;
        IROut    = ir;
        FlagsOut = fl;
        sb.push_back('{nm, e});
    endtask

    task automatic fetch_pair(input logic [15:0] ir, input logic [3:0] fl);
        cyc(1'b0, ir, fl, fetch_v(1'b0), "fetch0");
        cyc(1'b0, ir, fl, fetch_v(1'b1), "fetch1");
    endtask

    ctl_t e, init_v, br_v;

    initial begin
        init_v = idle_v(); init_v.arf_reg = 3'b100; init_v.arf_fun = 2'b11;
        br_v = idle_v(); br_v.mux_b = 2'b11; br_v.arf_reg = 3'b100; br_v.arf_fun = 2'b10;

        cyc(1'b1, 16'h0000, 4'h0, idle_v(), "reset_a");
        cyc(1'b1, 16'h0000, 4'h0, idle_v(), "reset_b");
        cyc(1'b0, 16'h0000, 4'h0, init_v, "init");

        // MOVL R3, 0x12
        fetch_pair(16'h1612, 4'h0);
        e = idle_v(); e.mux_a = 2'b11; e.rf_reg = 4'b0010; e.rf_fun = 3'b010;
        cyc(1'b0, 16'h1612, 4'h0, e, "movl_exec");

        // ADD R1 += R2
        fetch_pair(16'h1900, 4'h0);
        e = idle_v(); e.b_sel = 3'b001; e.alu_fun = 5'b10100; e.alu_wf = 1'b1;
        e.rf_reg = 4'b1000; e.rf_fun = 3'b010;
        cyc(1'b0, 16'h1900, 4'h0, e, "add_exec");

        // BNE not taken (Z=1), then taken (Z=0)
        fetch_pair(16'h0440, 4'b1000);
        cyc(1'b0, 16'h0440, 4'b1000, idle_v(), "bne_not_taken");
        fetch_pair(16'h0440, 4'b0000);
        cyc(1'b0, 16'h0440, 4'b0000, br_v, "bne_taken");

        // BEQ taken on Z=1, BEQ not taken with only C/N/O set, BRA
        fetch_pair(16'h0840, 4'b1000);
        cyc(1'b0, 16'h0840, 4'b1000, br_v, "beq_taken");
        fetch_pair(16'h0840, 4'b0111);
        cyc(1'b0, 16'h0840, 4'b0111, idle_v(), "beq_not_taken");
        fetch_pair(16'h0012, 4'b1000);
        cyc(1'b0, 16'h0012, 4'b1000, br_v, "bra");

        // INC R4, DEC R1
        fetch_pair(16'h0F00, 4'h0);
        e = idle_v(); e.rf_reg = 4'b0001; e.rf_fun = 3'b001;
        cyc(1'b0, 16'h0F00, 4'h0, e, "inc_r4");
        fetch_pair(16'h1000, 4'h0);
        e = idle_v(); e.rf_reg = 4'b1000; e.rf_fun = 3'b000;
        cyc(1'b0, 16'h1000, 4'h0, e, "dec_r1");

        // LD R2: four-cycle instruction
        fetch_pair(16'h1D00, 4'h0);
        e = idle_v(); e.d_sel = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun = 2'b01;
        cyc(1'b0, 16'h1D00, 4'h0, e, "ld_exec");
        e = idle_v(); e.mux_a = 2'b10; e.rf_reg = 4'b0100; e.rf_fun = 3'b010;
        cyc(1'b0, 16'h1D00, 4'h0, e, "ld_exec2");

        // Illegal opcode pulses for exactly one cycle
        fetch_pair(16'hFC00, 4'h0);
        e = idle_v(); e.illegal = 1'b1;
        cyc(1'b0, 16'hFC00, 4'h0, e, "illegal_exec");
        cyc(1'b0, 16'hFC00, 4'h0, fetch_v(1'b0), "after_illegal");
        cyc(1'b0, 16'hFC00, 4'h0, fetch_v(1'b1), "after_illegal_f1");

        // HLT, then halted for 10 cycles
        e = idle_v(); e.illegal = 1'b1;
        cyc(1'b0, 16'h2000, 4'h0, idle_v(), "hlt_exec");
        e = idle_v(); e.halted = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0000, 4'h0, e, "halted");

        // Reset out of HALT, then reset mid-fetch
        cyc(1'b1, 16'h0000, 4'h0, idle_v(), "reset_from_halt");
        cyc(1'b0, 16'h0000, 4'h0, init_v, "init2");
        cyc(1'b0, 16'h0000, 4'h0, fetch_v(1'b0), "fetch0_2");
        cyc(1'b1, 16'h0000, 4'h0, idle_v(), "reset_in_fetch1");
        cyc(1'b0, 16'h0000, 4'h0, init_v, "init3");
        cyc(1'b0, 16'h0000, 4'h0, fetch_v(1'b0), "fetch0_3");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge Clock);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
